// File: rtl/alu_cmd_queue.sv
// Command FIFO that feeds a combinational ALU and captures its result
// into a valid/ready output register.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    input  logic [2:0]                 in_op,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [2:0]                 alu_opcode,
    input  logic [3:0]                 alu_result,
    input  logic                       alu_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_result,
    output logic                       out_zero,
    output logic [2:0]                 out_op,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            not_empty;

    assign not_empty = (count != '0);
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && (!out_valid || out_ready);
    assign head      = mem[rd_ptr];

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (not_empty) begin
            alu_a      = head.a;
            alu_b      = head.b;
            alu_opcode = head.op;
        end
    end

    // Storage is deliberately left unreset; pointers and count guard it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_op      <= '0;
            out_illegal <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_result  <= alu_result;
            out_zero    <= alu_zero;
            out_op      <= head.op;
            out_illegal <= (head.op >= 3'b110);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001: The block SHALL have parameter DEPTH, default 4, command FIFO depth; legal values are powers of two from 2 to 16.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: in_valid  input  1  upstream command valid.
REQ-005: in_ready  output  1  queue can accept a command.
REQ-006: in_a, in_b  input  4 each  operands.
REQ-007: in_op  input  3  ALU opcode.
REQ-008: alu_a, alu_b  output  4 each  operands driven to the downstream ALU.
REQ-009: alu_opcode  output  3  opcode driven to the ALU.
REQ-010: alu_result  input  4  combinational ALU result.
REQ-011: alu_zero  input  1  combinational ALU zero flag.
REQ-012: out_valid  output  1  captured result valid.
REQ-013: out_ready  input  1  consumer accepts result.
REQ-014: out_result  output  4  captured result.
REQ-015: out_zero  output  1  captured zero flag.
REQ-016: out_op  output  3  opcode of the captured result.
REQ-017: out_illegal  output  1  captured opcode was 3'b110 or 3'b111.
REQ-018: count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-019: The queue SHALL store {in_a, in_b, in_op} per entry in a circular FIFO of DEPTH entries; read/write pointers wrap from DEPTH-1 to 0.
REQ-020: in_ready SHALL equal (count < DEPTH), computed from registered count only.
REQ-021: A push SHALL occur at a rising edge where in_valid && in_ready.
REQ-022: When full, no push SHALL occur even if a pop happens in the same cycle.
REQ-023: When count > 0, alu_a/alu_b/alu_opcode SHALL combinationally present the head entry.
REQ-024: When count == 0, alu_a/alu_b/alu_opcode SHALL be 0.
REQ-025: A pop SHALL occur at a rising edge where count > 0 && (!out_valid || out_ready).
REQ-026: On a pop, the block SHALL register alu_result, alu_zero and the head opcode into out_result/out_zero/out_op, set out_illegal = (head opcode >= 3'b110), and set out_valid = 1.
REQ-027: At an edge with out_valid && out_ready and no pop, out_valid SHALL go to 0; the data outputs SHALL hold their values.
REQ-028: While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-029: Latency: a command pushed at edge E into an empty queue with a free output register SHALL appear with out_valid = 1 after edge E+1.
REQ-030: Throughput SHALL be one command per cycle when out_ready is held at 1.
REQ-031: Simultaneous push and pop SHALL leave count unchanged.
REQ-032: A command written at edge E SHALL NOT be popped before edge E+1.
REQ-033: Ordering SHALL be strictly first-in first-out; arithmetic wrap-around is the ALU's (4-bit, carry and borrow dropped); the block performs no arithmetic.

Reset
REQ-034: rst_n low SHALL immediately clear pointers, count, out_valid, out_result, out_zero, out_op and out_illegal to 0, with in_ready = 1, independent of clk.
REQ-035: Reset asserted mid-operation SHALL discard all queued and captured commands; no out_valid pulse SHALL follow deassertion until a new push.
REQ-036: FIFO storage contents need not be reset.

Verification
REQ-037: Reset with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1, alu_* = 0 while rst_n is low.
REQ-038: Push A=3, B=5, op=000, out_ready=1 -> after the next edge: out_valid=1, out_result=8, out_zero=0, out_op=000.
REQ-039: Push A=15, B=1, op=000, then A=9, B=9, op=001 -> out_result=0, out_zero=1 for both, in order.
REQ-040: out_ready=0, 6 back-to-back pushes -> 5 accepted (1 in the output register, count=4), in_ready=0 on the 6th; raise out_ready -> results drain in order, one per cycle.
REQ-041: Push op=110, A=7, B=2 -> out_result=0, out_zero=1, out_illegal=1.
REQ-042: rst_n pulsed low with count=3 and out_valid=1 -> all cleared asynchronously; no out_valid after release without new pushes.
